// File: rtl/riscv_instr_aligner.sv
// Instruction aligner: turns word-aligned fetch words into one aligned
// instruction per handshake, splitting RVC pairs and stitching straddles.
module riscv_instr_aligner #(
    parameter bit C_RVC = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic [31:0] fetch_addr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_addr_o,
    output logic        instr_compressed_o
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL_LO = 2'd1,
        FULL_HI = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] buf_q;
    logic [31:2] buf_addr_q;
    logic        skip_q;

    logic        lo_c;
    logic        hi_c;
    logic [15:0] hi;
    logic        fetch_fire;
    logic        instr_fire;

    logic unused;
    assign unused = ^{fetch_addr_i[1:0], flush_addr_i[31:2], flush_addr_i[0]};

    assign hi   = buf_q[31:16];
    assign lo_c = C_RVC && (buf_q[1:0] != 2'b11);
    assign hi_c = C_RVC && (hi[1:0] != 2'b11);

    assign fetch_fire = fetch_valid_i & fetch_ready_o;
    assign instr_fire = instr_valid_o & instr_ready_i;

    always_comb begin
        fetch_ready_o      = 1'b0;
        instr_valid_o      = 1'b0;
        instr_rdata_o      = 32'h0;
        instr_addr_o       = 32'h0;
        instr_compressed_o = 1'b0;
        unique case (state)
            EMPTY: begin
                fetch_ready_o = 1'b1;
            end
            FULL_LO: begin
                instr_valid_o = 1'b1;
                instr_addr_o  = {buf_addr_q, 2'b00};
                if (lo_c) begin
                    instr_rdata_o      = {16'h0, buf_q[15:0]};
                    instr_compressed_o = 1'b1;
                end else begin
                    instr_rdata_o = buf_q;
                    fetch_ready_o = instr_ready_i;
                end
            end
            FULL_HI: begin
                instr_addr_o  = {buf_addr_q, 2'b10};
                fetch_ready_o = instr_ready_i;
                if (hi_c) begin
                    instr_valid_o      = 1'b1;
                    instr_rdata_o      = {16'h0, hi};
                    instr_compressed_o = 1'b1;
                end else begin
                    // straddle: upper half of the instruction is still on the fetch bus
                    instr_valid_o = fetch_valid_i;
                    instr_rdata_o = {fetch_rdata_i[15:0], hi};
                end
            end
            default: begin
                fetch_ready_o = 1'b0;
            end
        endcase
        if (flush_i) begin
            fetch_ready_o = 1'b0;
            instr_valid_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            skip_q     <= 1'b0;
            buf_q      <= 32'h0;
            buf_addr_q <= 30'h0;
        end else if (flush_i) begin
            state  <= EMPTY;
            skip_q <= flush_addr_i[1] & C_RVC;
        end else begin
            if (fetch_fire) begin
                buf_q      <= fetch_rdata_i;
                buf_addr_q <= fetch_addr_i[31:2];
            end
            unique case (state)
                EMPTY: begin
                    if (fetch_fire) begin
                        state  <= (skip_q && C_RVC) ? FULL_HI : FULL_LO;
                        skip_q <= 1'b0;
                    end
                end
                FULL_LO: begin
                    if (instr_fire) begin
                        if (lo_c)            state <= FULL_HI;
                        else if (fetch_fire) state <= FULL_LO;
                        else                 state <= EMPTY;
                    end
                end
                FULL_HI: begin
                    if (instr_fire) begin
                        if (!hi_c)           state <= FULL_HI;
                        else if (fetch_fire) state <= FULL_LO;
                        else                 state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
